// File: rtl/seq_nibble_mult_pkg.sv
// Shared constants, FSM state type and sizing helpers for the nibble-serial multiplier.
package seq_mult_pkg;

    localparam int unsigned NIBBLE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int unsigned nibbles(input int unsigned width);
        return width / NIBBLE;
    endfunction

    function automatic int unsigned ceil_log2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_nibble_mult_if.sv
// Operand/product handshake bundle between a producer (master) and the multiplier (slave).
interface seq_nibble_mult_if #(
    parameter int unsigned WIDTH = 8
);
    logic                 io_in_valid;
    logic                 io_in_ready;
    logic [WIDTH-1:0]     io_lhs;
    logic [WIDTH-1:0]     io_rhs;
    logic                 io_out_valid;
    logic                 io_out_ready;
    logic [2*WIDTH-1:0]   io_out;
    logic                 io_busy;

    modport master (
        output io_in_valid, io_lhs, io_rhs, io_out_ready,
        input  io_in_ready, io_out_valid, io_out, io_busy
    );

    modport slave (
        input  io_in_valid, io_lhs, io_rhs, io_out_ready,
        output io_in_ready, io_out_valid, io_out, io_busy
    );
endinterface

// File: rtl/seq_nibble_mult_rom.sv
// 256-entry 4x4 multiplication table: address {a,b}, data a*b, combinational read.
module nibble_mult_rom (
    input  logic [7:0] addr_i,
    output logic [7:0] data_o
);

    logic [7:0] rom_tbl [256];

    for (genvar k = 0; k < 256; k++) begin : g_rom
        localparam int unsigned A = k / 16;
        localparam int unsigned B = k % 16;
        assign rom_tbl[k] = 8'(A * B);
    end

    assign data_o = rom_tbl[addr_i];

endmodule

// File: rtl/seq_nibble_mult.sv
// Sequential WIDTH x WIDTH unsigned multiplier: one ROM nibble product per cycle,
// shifted into a 2*WIDTH accumulator, with valid/ready on both sides.
module seq_nibble_mult
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          ZERO_SKIP = 1'b1
) (
    input logic              clk,
    input logic              reset,
    seq_nibble_mult_if.slave bus
);

    localparam int unsigned N       = nibbles(WIDTH);
    localparam int unsigned IdxW    = (ceil_log2(N) > 0) ? ceil_log2(N) : 1;
    localparam int unsigned ShW     = IdxW + 3;
    localparam int unsigned AccW    = 2 * WIDTH;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  lhs_q, lhs_d, rhs_q, rhs_d;
    logic [AccW-1:0]   acc_q, acc_d;
    logic [IdxW-1:0]   i_q, i_d, j_q, j_d;

    logic [3:0]        lhs_nib, rhs_nib;
    logic [7:0]        pp;
    logic [ShW-1:0]    shamt;
    logic [AccW-1:0]   term;
    logic              last_term, skip;

    assign lhs_nib   = lhs_q[NIBBLE*i_q +: NIBBLE];
    assign rhs_nib   = rhs_q[NIBBLE*j_q +: NIBBLE];
    assign shamt     = (ShW'(i_q) + ShW'(j_q)) << 2;
    assign term      = AccW'(pp) << shamt;
    assign last_term = (i_q == LastIdx) && (j_q == LastIdx);
    // i=j=0 only holds on the first busy cycle, so this is the zero-operand shortcut
    assign skip      = ZERO_SKIP && (i_q == '0) && (j_q == '0) &&
                       ((lhs_q == '0) || (rhs_q == '0));

    nibble_mult_rom u_rom (
        .addr_i ({lhs_nib, rhs_nib}),
        .data_o (pp)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.io_in_valid) state_d = BUSY;
            BUSY:    if (skip || last_term) state_d = DONE;
            DONE:    if (bus.io_out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.io_in_ready  = (state_q == IDLE);
        bus.io_out_valid = (state_q == DONE);
        bus.io_busy      = (state_q == BUSY);
        bus.io_out       = acc_q;
    end

    always_comb begin
        lhs_d = lhs_q;
        rhs_d = rhs_q;
        acc_d = acc_q;
        i_d   = i_q;
        j_d   = j_q;
        if (state_q == IDLE && bus.io_in_valid) begin
            lhs_d = bus.io_lhs;
            rhs_d = bus.io_rhs;
            acc_d = '0;
            i_d   = '0;
            j_d   = '0;
        end else if (state_q == BUSY && !skip) begin
            acc_d = acc_q + term;
            if (j_q == LastIdx) begin
                j_d = '0;
                i_d = last_term ? '0 : i_q + 1'b1;
            end else begin
                j_d = j_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lhs_q <= '0;
            rhs_q <= '0;
            acc_q <= '0;
            i_q   <= '0;
            j_q   <= '0;
        end else begin
            lhs_q <= lhs_d;
            rhs_q <= rhs_d;
            acc_q <= acc_d;
            i_q   <= i_d;
            j_q   <= j_d;
        end
    end

endmodule

// File: tb/tb_seq_nibble_mult.sv
// Directed and randomized checks of seq_nibble_mult at WIDTH 4/8/16 against a
// plain-arithmetic product and latency model.
module tb_seq_nibble_mult;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  vld;
    logic        out_rdy;
    logic [15:0] lhs, rhs;

    always #5 clk = ~clk;

    seq_nibble_mult_if #(.WIDTH(8))  if8  ();
    seq_nibble_mult_if #(.WIDTH(8))  if8n ();
    seq_nibble_mult_if #(.WIDTH(16)) if16 ();
    seq_nibble_mult_if #(.WIDTH(4))  if4  ();

    assign if8.io_in_valid   = vld[0];
    assign if8.io_lhs        = lhs[7:0];
    assign if8.io_rhs        = rhs[7:0];
    assign if8.io_out_ready  = out_rdy;
    assign if8n.io_in_valid  = vld[1];
    assign if8n.io_lhs       = lhs[7:0];
    assign if8n.io_rhs       = rhs[7:0];
    assign if8n.io_out_ready = out_rdy;
    assign if16.io_in_valid  = vld[2];
    assign if16.io_lhs       = lhs;
    assign if16.io_rhs       = rhs;
    assign if16.io_out_ready = out_rdy;
    assign if4.io_in_valid   = vld[3];
    assign if4.io_lhs        = lhs[3:0];
    assign if4.io_rhs        = rhs[3:0];
    assign if4.io_out_ready  = out_rdy;

    seq_nibble_mult #(.WIDTH(8), .ZERO_SKIP(1'b1)) u_w8 (
        .clk(clk), .reset(reset), .bus(if8));
    seq_nibble_mult #(.WIDTH(8), .ZERO_SKIP(1'b0)) u_w8n (
        .clk(clk), .reset(reset), .bus(if8n));
    seq_nibble_mult #(.WIDTH(16), .ZERO_SKIP(1'b1)) u_w16 (
        .clk(clk), .reset(reset), .bus(if16));
    seq_nibble_mult #(.WIDTH(4), .ZERO_SKIP(1'b1)) u_w4 (
        .clk(clk), .reset(reset), .bus(if4));

    logic        rdy_o  [4];
    logic        ov_o   [4];
    logic        busy_o [4];
    logic [31:0] out_o  [4];

    assign rdy_o[0] = if8.io_in_ready;   assign ov_o[0] = if8.io_out_valid;
    assign rdy_o[1] = if8n.io_in_ready;  assign ov_o[1] = if8n.io_out_valid;
    assign rdy_o[2] = if16.io_in_ready;  assign ov_o[2] = if16.io_out_valid;
    assign rdy_o[3] = if4.io_in_ready;   assign ov_o[3] = if4.io_out_valid;
    assign busy_o[0] = if8.io_busy;      assign out_o[0] = 32'(if8.io_out);
    assign busy_o[1] = if8n.io_busy;     assign out_o[1] = 32'(if8n.io_out);
    assign busy_o[2] = if16.io_busy;     assign out_o[2] = if16.io_out;
    assign busy_o[3] = if4.io_busy;      assign out_o[3] = 32'(if4.io_out);

    int tests = 0;
    int fails = 0;

    function automatic int width_of(input int sel);
        case (sel)
            2:       return 16;
            3:       return 4;
            default: return 8;
        endcase
    endfunction

    function automatic bit zs_of(input int sel);
        return (sel != 1);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction on DUT sel; model is plain multiplication plus N*N latency.
    task automatic txn(input int sel, input logic [15:0] a, input logic [15:0] b,
                       input int hold, input bit disturb);
        int          w     = width_of(sel);
        int          n     = w / 4;
        logic [31:0] mask  = (32'h1 << w) - 1;
        logic [31:0] am    = 32'(a) & mask;
        logic [31:0] bm    = 32'(b) & mask;
        logic [31:0] exp_p = am * bm;
        int          exp_busy;
        int          cnt   = 0;
        bit          done  = 1'b0;
        exp_busy = (zs_of(sel) && (am == 0 || bm == 0)) ? 1 : n * n;

        @(negedge clk);
        check("ready_before_accept", 64'(rdy_o[sel]), 64'd1);
        lhs = a;
        rhs = b;
        vld[sel] = 1'b1;
        @(negedge clk);
        vld[sel] = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            if (ov_o[sel]) begin
                done = 1'b1;
            end else begin
                check("busy_high", 64'(busy_o[sel]), 64'd1);
                check("in_ready_low_busy", 64'(rdy_o[sel]), 64'd0);
                cnt++;
                if (disturb) begin
                    vld[sel] = k[0];
                    lhs = 16'h0011;
                end
                @(negedge clk);
            end
        end
        vld[sel] = 1'b0;
        check("done_within_bound", 64'(done), 64'd1);
        check("busy_cycles", 64'(cnt), 64'(exp_busy));
        check("product", 64'(out_o[sel]), 64'(exp_p));
        check("in_ready_low_done", 64'(rdy_o[sel]), 64'd0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("valid_held", 64'(ov_o[sel]), 64'd1);
            check("product_held", 64'(out_o[sel]), 64'(exp_p));
        end
        out_rdy = 1'b1;
        @(negedge clk);
        out_rdy = 1'b0;
        check("idle_after_take", 64'(rdy_o[sel]), 64'd1);
        check("valid_dropped", 64'(ov_o[sel]), 64'd0);
        check("acc_kept", 64'(out_o[sel]), 64'(exp_p));
    endtask

    initial begin
        reset   = 1'b0;
        vld     = '0;
        out_rdy = 1'b0;
        lhs     = '0;
        rhs     = '0;
        #1;
        for (int s = 0; s < 4; s++) begin
            check("rst_in_ready", 64'(rdy_o[s]), 64'd1);
            check("rst_out_valid", 64'(ov_o[s]), 64'd0);
            check("rst_busy", 64'(busy_o[s]), 64'd0);
            check("rst_out", 64'(out_o[s]), 64'd0);
        end
        @(negedge clk);
        reset = 1'b1;

        txn(0, 16'h00FF, 16'h00FF, 0, 1'b0);
        check("ff_x_ff", 64'(out_o[0]), 64'h0000FE01);
        txn(0, 16'h0000, 16'h00A7, 0, 1'b0);
        txn(1, 16'h0000, 16'h00A7, 0, 1'b0);
        txn(2, 16'h1234, 16'hABCD, 5, 1'b0);
        check("w16_known", 64'(out_o[2]), 64'h0C374FA4);
        txn(0, 16'h0035, 16'h004C, 0, 1'b1);
        check("disturb_known", 64'(out_o[0]), 64'h00000FBC);

        // Reset in the middle of BUSY discards the partial product.
        @(negedge clk);
        lhs = 16'h00C3;
        rhs = 16'h005A;
        vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_in_ready", 64'(rdy_o[0]), 64'd1);
        check("midrst_out_valid", 64'(ov_o[0]), 64'd0);
        check("midrst_busy", 64'(busy_o[0]), 64'd0);
        check("midrst_out", 64'(out_o[0]), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        txn(0, 16'h0002, 16'h0003, 0, 1'b0);
        check("post_rst_known", 64'(out_o[0]), 64'h00000006);

        for (int t = 0; t < 200; t++) begin
            txn(3, 16'($urandom), 16'($urandom), int'($urandom_range(0, 2)), 1'b0);
        end
        for (int t = 0; t < 10; t++) begin
            txn(0, 16'($urandom), 16'($urandom), int'($urandom_range(0, 2)), 1'b0);
            txn(1, 16'($urandom), 16'($urandom), 0, 1'b0);
        end
        for (int t = 0; t < 5; t++) begin
            txn(2, 16'($urandom), 16'($urandom), int'($urandom_range(0, 1)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
